// File: rtl/axil_write_arbiter.sv
// Per-slave AXI-Lite write-channel arbiter: grants one master for a whole AW/W/B transaction.
// Optional macro AXIL_ARB_ROUND_ROBIN_EN switches fixed lowest-index priority to round-robin.
module axil_write_arbiter #(
    parameter int NUMBER_MASTER = 32,
    parameter int IDX_W         = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUMBER_MASTER-1:0] req,
    input  logic                     aw_hs,
    input  logic                     w_hs,
    input  logic                     b_hs,
    output logic [NUMBER_MASTER-1:0] grant,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     grant_valid,
    output logic                     aw_open,
    output logic                     w_open
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                     r_state;
    logic [NUMBER_MASTER-1:0]   r_grant;
    logic [IDX_W-1:0]           r_grant_idx;
    logic                       r_grant_valid;
    logic                       r_aw_open;
    logic                       r_w_open;

    state_t                     w_state_nxt;
    logic [NUMBER_MASTER-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]           w_grant_idx_nxt;
    logic                       w_grant_valid_nxt;
    logic                       w_aw_open_nxt;
    logic                       w_w_open_nxt;
    logic                       w_load;

    logic                       w_any_req;
    logic [IDX_W-1:0]           w_lo_idx;
    logic [IDX_W-1:0]           w_winner;
    logic [NUMBER_MASTER-1:0]   w_winner_onehot;

    assign w_any_req = |req;

    // Lowest-index requester; scanning downward lets the last hit win.
    always_comb begin
        w_lo_idx = '0;
        for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
            if (req[i]) w_lo_idx = IDX_W'(i);
        end
    end

`ifdef AXIL_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_last_idx;
    logic [IDX_W-1:0] w_hi_idx;
    logic             w_hi_found;

    // Prefer the lowest requester above the last winner, else wrap to the lowest overall.
    always_comb begin
        w_hi_idx   = '0;
        w_hi_found = 1'b0;
        for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(r_last_idx))) begin
                w_hi_idx   = IDX_W'(i);
                w_hi_found = 1'b1;
            end
        end
        w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)    r_last_idx <= '0;
        else if (w_load) r_last_idx <= w_winner;
    end
`else
    assign w_winner = w_lo_idx;
`endif

    always_comb begin
        w_winner_onehot           = '0;
        w_winner_onehot[w_winner] = 1'b1;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_grant_idx_nxt   = r_grant_idx;
        w_grant_valid_nxt = r_grant_valid;
        w_aw_open_nxt     = r_aw_open;
        w_w_open_nxt      = r_w_open;
        w_load            = 1'b0;

        unique case (r_state)
            ST_IDLE: w_load = w_any_req;
            ST_XFER: begin
                if (aw_hs) w_aw_open_nxt = 1'b0;
                if (w_hs)  w_w_open_nxt  = 1'b0;
                if (!w_aw_open_nxt && !w_w_open_nxt) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (b_hs) begin
                    if (w_any_req) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt       = ST_IDLE;
                        w_grant_nxt       = '0;
                        w_grant_idx_nxt   = '0;
                        w_grant_valid_nxt = 1'b0;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_load) begin
            w_state_nxt       = ST_XFER;
            w_grant_nxt       = w_winner_onehot;
            w_grant_idx_nxt   = w_winner;
            w_grant_valid_nxt = 1'b1;
            w_aw_open_nxt     = 1'b1;
            w_w_open_nxt      = 1'b1;
        end
    end

    // Asynchronous reset drops the grant at once, without waiting for an edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_aw_open     <= 1'b0;
            r_w_open      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_idx   <= w_grant_idx_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_aw_open     <= w_aw_open_nxt;
            r_w_open      <= w_w_open_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign aw_open     = r_aw_open;
    assign w_open      = r_w_open;

endmodule

// File: tb/tb_axil_write_arbiter.sv
// Scoreboard bench for axil_write_arbiter: a transaction-level model predicts each cycle's
// outputs into a queue, and an independent monitor compares them after every rising edge.
module tb_axil_write_arbiter;

    localparam int N  = 32;
    localparam int IW = 5;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [N-1:0]  req = '0;
    logic          aw_hs = 1'b0;
    logic          w_hs = 1'b0;
    logic          b_hs = 1'b0;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          grant_valid;
    logic          aw_open;
    logic          w_open;

    axil_write_arbiter #(.NUMBER_MASTER(N)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .req         (req),
        .aw_hs       (aw_hs),
        .w_hs        (w_hs),
        .b_hs        (b_hs),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .aw_open     (aw_open),
        .w_open      (w_open)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [N-1:0] grant;
        int           idx;
        bit           valid;
        bit           aw;
        bit           w;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    // Model: who holds the slave and which halves of the write are still outstanding.
    int m_holder = -1;
    bit m_aw_pending = 1'b0;
    bit m_w_pending  = 1'b0;
    int m_last = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_val);
        checks++;
        if (act !== req_val) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req_val, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
`ifdef AXIL_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            if (r[(m_last + k) % N]) return (m_last + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic void grant_to(input int j);
        m_holder     = j;
        m_aw_pending = 1'b1;
        m_w_pending  = 1'b1;
        m_last       = j;
    endfunction

    function automatic void model_apply(input logic [N-1:0] r, input bit a, input bit w, input bit b);
        if (m_holder < 0) begin
            if (r != 0) grant_to(pick(r));
        end else if (m_aw_pending || m_w_pending) begin
            if (a) m_aw_pending = 1'b0;
            if (w) m_w_pending  = 1'b0;
        end else if (b) begin
            if (r != 0) grant_to(pick(r));
            else        m_holder = -1;
        end
    endfunction

    function automatic void model_reset();
        m_holder     = -1;
        m_aw_pending = 1'b0;
        m_w_pending  = 1'b0;
        m_last       = 0;
    endfunction

    task automatic drive(input logic [N-1:0] r, input bit a, input bit w, input bit b);
        exp_t         e;
        logic [N-1:0] one;
        req   = r;
        aw_hs = a;
        w_hs  = w;
        b_hs  = b;
        model_apply(r, a, w, b);
        one     = 1;
        e.valid = (m_holder >= 0);
        e.grant = e.valid ? (one << m_holder) : '0;
        e.idx   = e.valid ? m_holder : 0;
        e.aw    = m_aw_pending;
        e.w     = m_w_pending;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [N-1:0] r, input bit a, input bit w, input bit b);
        @(negedge aclk);
        drive(r, a, w, b);
    endtask

    // Monitor: one prediction per rising edge, compared just after the edge.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("grant", 64'(grant), 64'(mon_e.grant));
                check("grant_valid", 64'(grant_valid), 64'(mon_e.valid));
                if (mon_e.valid) check("grant_idx", 64'(grant_idx), 64'(mon_e.idx));
                check("aw_open", 64'(aw_open), 64'(mon_e.aw));
                check("w_open", 64'(w_open), 64'(mon_e.w));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] r;
        int           sel;

        repeat (3) @(posedge aclk);
        #1;
        check("reset_grant", 64'(grant), 64'(0));
        check("reset_grant_valid", 64'(grant_valid), 64'(0));
        check("reset_aw_open", 64'(aw_open), 64'(0));
        check("reset_w_open", 64'(w_open), 64'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        drive('0, 0, 0, 0);
        repeat (10) step('0, 0, 0, 0);

        // Single write, W before AW.
        step(32'h4, 0, 0, 0);
        step(32'h4, 0, 1, 0);
        step(32'h4, 1, 0, 0);
        step(32'h4, 0, 0, 0);
        step('0, 0, 0, 1);
        step('0, 0, 0, 0);

        // Contention with 0xC05 held, re-arbitrating back-to-back, then bit 0 drops.
        step(32'hC05, 0, 0, 0);
        step(32'hC05, 1, 1, 0);
        step(32'hC05, 0, 0, 1);
        step(32'hC05, 1, 1, 0);
        step(32'hC05, 0, 0, 1);
        step(32'hC05, 1, 1, 0);
        step(32'hC04, 0, 0, 1);
        step('0, 1, 1, 0);
        step('0, 0, 0, 1);
        step('0, 0, 0, 0);

        // Simultaneous handshakes, back-to-back grant, stray handshakes in RESP/XFER.
        step(32'h1, 0, 0, 0);
        step(32'h1, 1, 1, 0);
        step(32'h2, 1, 1, 1);
        step('0, 1, 0, 1);
        step('0, 1, 1, 0);
        step('0, 0, 1, 0);
        step('0, 0, 0, 1);
        step('0, 0, 0, 0);

        // Asynchronous reset while in RESP.
        step(32'h1, 0, 0, 0);
        step(32'h0, 1, 1, 0);
        @(posedge aclk);
        #2;
        req = '0; aw_hs = 1'b0; w_hs = 1'b0; b_hs = 1'b0;
        aresetn = 1'b0;
        #1;
        check("async_grant", 64'(grant), 64'(0));
        check("async_grant_valid", 64'(grant_valid), 64'(0));
        check("async_aw_open", 64'(aw_open), 64'(0));
        check("async_w_open", 64'(w_open), 64'(0));
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;
        drive('0, 0, 0, 0);
        step(32'h1, 0, 0, 0);
        step('0, 1, 1, 0);
        step('0, 0, 0, 1);

        // Randomized traffic with sparse request patterns.
        for (int c = 0; c < 2000; c++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2)      r = '0;
            else if (sel < 5) r = N'(1) << $urandom_range(0, N - 1);
            else              r = N'($urandom & $urandom & $urandom);
            step(r, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0));
        end

        step('0, 0, 0, 0);
        @(posedge aclk);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
